bram32_frame_loader: RTL
========================

// Module: bram32_frame_loader
// PURPOSE
//  Upstream write stage for the 32x13 multi-read-port sample BRAM.
//  - Accepts a valid/ready sample stream and drives the BRAM's single write port.
//  - Fills one frame, in linear or bit-reversed address order.
//  - Flags the frame ready to the 18 downstream readers, then stalls input until they release it.
// PARAMETERS
//  DATA_W     13  sample width; equals BRAM write_data width
//  ADDR_W     5   BRAM address width
//  FRAME_LEN  32  words per full frame, 2..2**ADDR_W; bit-reverse legal only when FRAME_LEN==2**ADDR_W
// PORTS
//  clk              in   1          sole clock, rising edge
//  rst              in   1          synchronous, active-high reset
//  in_valid         in   1          sample valid
//  in_data          in   DATA_W     sample
//  in_last          in   1          marks final sample of a (possibly short) frame
//  in_ready         out  1          loader accepts sample this cycle
//  bitrev_mode      in   1          1 = bit-reversed write addresses; sampled on first word of frame
//  frame_release    in   1          1-cycle pulse: readers finished with held frame
//  bram_write_en    out  1          to BRAM write_en
//  bram_write_addr  out  ADDR_W     to BRAM write_addr
//  bram_write_data  out  DATA_W     to BRAM write_data
//  frame_ready      out  1          BRAM holds a complete frame; readers may issue reads
//  frame_words      out  ADDR_W+1   word count of held frame, 1..FRAME_LEN
//  short_frame      out  1          held frame ended by in_last before FRAME_LEN words
//  frame_count      out  8          frames completed; wraps 255->0
// BEHAVIOUR
//  Reset (rst=1 at a rising edge):
//   - State LOAD.
//   - in_ready, bram_write_en, frame_ready, short_frame = 0.
//   - bram_write_addr, bram_write_data, frame_words, frame_count = 0.
//   - Word counter cleared; any partially loaded frame is discarded.
//  States:
//   - LOAD:  in_ready=1. Handshake = in_valid & in_ready.
//   - FLUSH: one cycle; lets the last BRAM write land. in_ready=0.
//   - HOLD:  in_ready=0, frame_ready=1. Waits for frame_release.
//  Write path (registered, 1-cycle latency):
//   - A handshake at edge k drives bram_write_en=1 with addr/data after edge k; BRAM captures at edge k+1.
//   - bram_write_en=0 in every cycle without a handshake; addr/data hold their last value.
//   - Addr for word index n: bitrev_mode=0 -> n; bitrev_mode=1 -> n with ADDR_W bits reversed.
//   - bitrev_mode is latched at the word-0 handshake and fixed for the whole frame.
//  Frame end, on the handshake of word n, when (n==FRAME_LEN-1) | in_last:
//   - Next state FLUSH.
//   - frame_words <= n+1.
//   - short_frame <= (n < FRAME_LEN-1).
//   - in_last on word FRAME_LEN-1 is legal; in_last is ignored except at a frame end.
//   - in_last on word 0 gives a 1-word short frame.
//  FLUSH -> HOLD unconditionally:
//   - frame_ready rises after the edge following the final BRAM capture.
//   - frame_count increments on this transition.
//  HOLD -> LOAD on frame_release=1:
//   - frame_ready=0 and in_ready=1 from the next cycle.
//   - Word counter cleared.
//  frame_release outside HOLD is ignored; it is not queued.
//  frame_words and short_frame hold their values until the next frame end.
//  No input is lost: input is stalled only via in_ready=0.
// TESTING
//  - rst held 3 cycles, then released:
//    -> all outputs 0 during reset; in_ready=1 on the first cycle after release.
//  - 32 back-to-back words 0..31, bitrev_mode=0:
//    -> writes addr n / data n;
//    -> frame_ready=1 two cycles after the 32nd handshake;
//    -> frame_words=32, short_frame=0, frame_count=1, in_ready=0.
//  - bitrev_mode=1, data 100+n:
//    -> word 1 at addr 16, word 3 at addr 24, word 31 at addr 31.
//    -> Toggling bitrev_mode mid-frame changes nothing.
//  - in_last on the 5th word:
//    -> frame_words=5, short_frame=1, frame_ready=1;
//    -> frame_release -> in_ready=1 next cycle; next frame starts at addr 0.
//  - frame_release pulsed during LOAD, then in HOLD with in_valid=1 held:
//    -> the LOAD-time pulse is ignored;
//    -> no handshake while in HOLD;
//    -> the first new word is accepted the cycle after the HOLD release.
//  - rst asserted after 10 words, then 32 words sent:
//    -> no frame_ready from the partial frame; frame_count=1 after the full frame.

Source files
------------

// File: rtl/bram32_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : bram32_frame_loader
//  Description : Write stage for the 32x13 multi-read-port sample BRAM.
//                Accepts a valid/ready sample stream, fills one frame in
//                linear or bit-reversed address order, then holds the frame
//                for the downstream readers until they release it.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram32_frame_loader #(
    parameter int DATA_W    = 13,
    parameter int ADDR_W    = 5,
    parameter int FRAME_LEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              bitrev_mode,
    input  logic              frame_release,
    output logic              bram_write_en,
    output logic [ADDR_W-1:0] bram_write_addr,
    output logic [DATA_W-1:0] bram_write_data,
    output logic              frame_ready,
    output logic [ADDR_W:0]   frame_words,
    output logic              short_frame,
    output logic [7:0]        frame_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q;
    logic                frame_ready_q;
    logic [ADDR_W-1:0]   word_cnt_q;
    logic                bitrev_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [ADDR_W:0]     frame_words_q;
    logic                short_frame_q;
    logic [7:0]          frame_count_q;

    logic                hs;
    logic                frame_end;
    logic                use_rev;
    logic [ADDR_W-1:0]   addr_rev;
    logic [ADDR_W-1:0]   addr_next;

    assign hs        = in_valid & in_ready_q;
    assign frame_end = hs & ((word_cnt_q == LAST_IDX) | in_last);
    // Mode is taken live on word 0 and from the latched copy afterwards.
    assign use_rev   = (word_cnt_q == '0) ? bitrev_mode : bitrev_q;

    generate
        for (genvar i = 0; i < ADDR_W; i++) begin : g_bitrev
            assign addr_rev[i] = word_cnt_q[ADDR_W-1-i];
        end
    endgenerate

    assign addr_next = use_rev ? addr_rev : word_cnt_q;

    // Next-state logic for the LOAD / FLUSH / HOLD sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (frame_end) state_d = FLUSH;
            FLUSH:   state_d = HOLD;
            HOLD:    if (frame_release) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // State, write-port, word-counter and frame-status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LOAD;
            in_ready_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            word_cnt_q    <= '0;
            bitrev_q      <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_words_q <= '0;
            short_frame_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == LOAD);
            // Ready rises one cycle into HOLD, after the final write has settled;
            // it drops together with the release so readers never see a stale flag.
            frame_ready_q <= (state_q == HOLD) & ~frame_release;

            wr_en_q <= hs;
            if (hs) begin
                wr_addr_q <= addr_next;
                wr_data_q <= in_data;
                if (word_cnt_q == '0) begin
                    bitrev_q <= bitrev_mode;
                end
                if (frame_end) begin
                    word_cnt_q    <= '0;
                    frame_words_q <= (ADDR_W+1)'(word_cnt_q) + 1'b1;
                    short_frame_q <= (word_cnt_q != LAST_IDX);
                end else begin
                    word_cnt_q <= word_cnt_q + 1'b1;
                end
            end

            if ((state_q == HOLD) && frame_release) begin
                word_cnt_q <= '0;
            end

            if (state_q == FLUSH) begin
                frame_count_q <= frame_count_q + 8'd1;
            end
        end
    end

    assign in_ready        = in_ready_q;
    assign bram_write_en   = wr_en_q;
    assign bram_write_addr = wr_addr_q;
    assign bram_write_data = wr_data_q;
    assign frame_ready     = frame_ready_q;
    assign frame_words     = frame_words_q;
    assign short_frame     = short_frame_q;
    assign frame_count     = frame_count_q;

endmodule
`default_nettype wire
